// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, FSM states, forward selects.
// Pure definitions, no logic or latency.
// No flow control of its own.
package ex_pkg;

  // aLUCtrl operation codes; 12..15 are unused and produce zero.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_SRA = 4'd9;
  localparam logic [3:0] ALU_LUI = 4'd10;
  localparam logic [3:0] ALU_MUL = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ex_state_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_t;

  // EX/MEM beats MEM/WB because it holds the younger value; r0 never forwards.
  function automatic fwd_sel_t fwd_select(input logic       exmem_we,
                                          input logic [4:0] exmem_rd,
                                          input logic       memwb_we,
                                          input logic [4:0] memwb_rd,
                                          input logic [4:0] idx);
    fwd_sel_t sel;
    sel = FWD_REG;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == idx))
      sel = FWD_EXMEM;
    else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == idx))
      sel = FWD_MEMWB;
    return sel;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing the low DATA_W bits of a*b.
// Latency: one iteration per step cycle, MUL_ITER steps after start.
// No backpressure: the owner asserts step only while it is waiting for the product.
module seq_multiplier #(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] product,
  output logic              done
);

  localparam int CNT_W = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [CNT_W-1:0]  cnt;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
      cnt     <= '0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      product <= '0;
      cnt     <= '0;
    end else if (step) begin
      if (mplier[0])
        product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // Strobe on the cycle whose edge performs the final iteration.
  assign done = step && (cnt == CNT_W'(MUL_ITER - 1));

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, beq compare, EX/MEM register, iterative MUL.
// Latency: 1 cycle for ALU ops, MUL_ITER+2 cycles for MUL.
// Backpressure: stall_req freezes upstream while a MUL is in flight; EX/MEM takes bubbles meanwhile.
module ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MUL_ITER = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch,
  input  logic              regWrite,
  input  logic              regDst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memtoReg,
  input  logic              aLUSrc1,
  input  logic              aLUSrc2,
  input  logic              sign,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [DATA_W-1:0] immOrShamt,
  input  logic [3:0]        aLUCtrl,
  input  logic              wb_regWrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              branch_taken,
  output logic              stall_req,
  output logic              mem_regWrite,
  output logic              mem_memRead,
  output logic              mem_memWrite,
  output logic              mem_memtoReg,
  output logic [DATA_W-1:0] mem_alu_result,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [4:0]        mem_rd
);

  ex_state_t         state, state_nxt;
  fwd_sel_t          sel_a, sel_b;
  logic [DATA_W-1:0] fwd_a, fwd_b, op_a, op_b, alu_res;
  logic [4:0]        dest;
  logic [4:0]        shamt;
  logic              slt_lt;

  logic              mul_start, mul_step, mul_done;
  logic [DATA_W-1:0] mul_product;
  logic              ctx_regWrite, ctx_memtoReg;
  logic [4:0]        ctx_dest;

  logic              n_regWrite, n_memRead, n_memWrite, n_memtoReg;
  logic [DATA_W-1:0] n_result, n_store;
  logic [4:0]        n_rd;

  assign sel_a = fwd_select(mem_regWrite, mem_rd, wb_regWrite, wb_rd, rs);
  assign sel_b = fwd_select(mem_regWrite, mem_rd, wb_regWrite, wb_rd, rt);

  // Operand A forwarding mux.
  always_comb begin
    case (sel_a)
      FWD_EXMEM: fwd_a = mem_alu_result;
      FWD_MEMWB: fwd_a = wb_data;
      default:   fwd_a = rs_data;
    endcase
  end

  // Operand B forwarding mux.
  always_comb begin
    case (sel_b)
      FWD_EXMEM: fwd_b = mem_alu_result;
      FWD_MEMWB: fwd_b = wb_data;
      default:   fwd_b = rt_data;
    endcase
  end

  assign op_a  = aLUSrc1 ? DATA_W'(immOrShamt[4:0]) : fwd_a;
  assign op_b  = aLUSrc2 ? immOrShamt : fwd_b;
  assign dest  = regDst ? rd : rt;
  assign shamt = op_a[4:0];
  assign slt_lt = sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

  // beq only resolves while no multiply owns the stage.
  assign branch_taken = branch && (fwd_a == fwd_b) && (state == ST_IDLE);

  // Single-cycle ALU; MUL is handled by the sequential multiplier, so it yields zero here.
  always_comb begin
    alu_res = '0;
    case (aLUCtrl)
      ALU_ADD: alu_res = op_a + op_b;
      ALU_SUB: alu_res = op_a - op_b;
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOR: alu_res = ~(op_a | op_b);
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt_lt};
      ALU_SLL: alu_res = op_b << shamt;
      ALU_SRL: alu_res = op_b >> shamt;
      ALU_SRA: alu_res = $signed(op_b) >>> shamt;
      ALU_LUI: alu_res = op_b << 16;
      default: alu_res = '0;
    endcase
  end

  seq_multiplier #(
    .DATA_W   (DATA_W),
    .MUL_ITER (MUL_ITER)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .step    (mul_step),
    .a       (fwd_a),
    .b       (fwd_b),
    .product (mul_product),
    .done    (mul_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Next state, stall request and EX/MEM next values; a bubble is the default load.
  always_comb begin
    state_nxt  = state;
    stall_req  = 1'b0;
    mul_start  = 1'b0;
    mul_step   = 1'b0;
    n_regWrite = 1'b0;
    n_memRead  = 1'b0;
    n_memWrite = 1'b0;
    n_memtoReg = 1'b0;
    n_result   = '0;
    n_store    = '0;
    n_rd       = '0;
    case (state)
      ST_IDLE: begin
        if (aLUCtrl == ALU_MUL) begin
          stall_req = 1'b1;
          mul_start = 1'b1;
          state_nxt = ST_BUSY;
        end else begin
          n_regWrite = regWrite;
          n_memRead  = memRead;
          n_memWrite = memWrite;
          n_memtoReg = memtoReg;
          n_result   = alu_res;
          n_store    = fwd_b;
          n_rd       = dest;
        end
      end
      ST_BUSY: begin
        stall_req = 1'b1;
        mul_step  = 1'b1;
        if (mul_done)
          state_nxt = ST_DONE;
      end
      ST_DONE: begin
        n_regWrite = ctx_regWrite;
        n_memtoReg = ctx_memtoReg;
        n_result   = mul_product;
        n_rd       = ctx_dest;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Writeback context of the multiply, captured as it is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctx_regWrite <= 1'b0;
      ctx_memtoReg <= 1'b0;
      ctx_dest     <= '0;
    end else if (mul_start) begin
      ctx_regWrite <= regWrite;
      ctx_memtoReg <= memtoReg;
      ctx_dest     <= dest;
    end
  end

  // EX/MEM pipeline register, loaded every cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_regWrite   <= 1'b0;
      mem_memRead    <= 1'b0;
      mem_memWrite   <= 1'b0;
      mem_memtoReg   <= 1'b0;
      mem_alu_result <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
    end else begin
      mem_regWrite   <= n_regWrite;
      mem_memRead    <= n_memRead;
      mem_memWrite   <= n_memWrite;
      mem_memtoReg   <= n_memtoReg;
      mem_alu_result <= n_result;
      mem_store_data <= n_store;
      mem_rd         <= n_rd;
    end
  end

endmodule
